// File: rtl/centering_unit.sv
// centering_unit: buffers a frame of N two-channel signed samples, derives the
// floor mean of each channel, then streams the zero-mean samples downstream.
module centering_unit #(
  parameter int N     = 128,
  parameter int LOG2N = 7,
  parameter int W     = 16
) (
  input  logic                CLK,
  input  logic                GO,
  input  logic                IN_valid,
  output logic                IN_ready,
  input  logic signed [W-1:0] IN_x1,
  input  logic signed [W-1:0] IN_x2,
  output logic                OUT_valid,
  input  logic                OUT_ready,
  output logic signed [W:0]   OUT_x1,
  output logic signed [W:0]   OUT_x2,
  output logic signed [W-1:0] MEAN_x1,
  output logic signed [W-1:0] MEAN_x2,
  output logic                CEN_busy
);

  localparam int SW = W + LOG2N;

  typedef enum logic [1:0] {
    S_LOAD = 2'd0,
    S_MEAN = 2'd1,
    S_OUT  = 2'd2,
    S_DONE = 2'd3
  } state_e;

  state_e               state_q, state_d;
  logic [LOG2N-1:0]     wcnt_q, wcnt_d;
  logic [LOG2N-1:0]     rcnt_q, rcnt_d;
  logic signed [SW-1:0] sum1_q, sum1_d;
  logic signed [SW-1:0] sum2_q, sum2_d;
  logic                 in_ready_q, in_ready_d;
  logic                 out_valid_q, out_valid_d;
  logic                 busy_q, busy_d;
  logic signed [W:0]    out1_q, out1_d;
  logic signed [W:0]    out2_q, out2_d;
  logic signed [W-1:0]  mean1_q, mean1_d;
  logic signed [W-1:0]  mean2_q, mean2_d;

  logic [W-1:0]         buf1 [N];
  logic [W-1:0]         buf2 [N];
  logic signed [W-1:0]  rd1_q, rd2_q;

  logic                 wr_en_s;
  logic                 rd_en_s;
  logic [LOG2N-1:0]     rd_addr_s;
  logic                 in_xfer_s;
  logic signed [W:0]    diff1_s, diff2_s;

  // in_ready_q is only ever high in S_LOAD, so it also qualifies the state
  assign in_xfer_s = IN_valid & in_ready_q;
  assign diff1_s   = {rd1_q[W-1], rd1_q} - {mean1_q[W-1], mean1_q};
  assign diff2_s   = {rd2_q[W-1], rd2_q} - {mean2_q[W-1], mean2_q};

  // Next-state, datapath and buffer-port control
  always_comb begin
    state_d     = state_q;
    wcnt_d      = wcnt_q;
    rcnt_d      = rcnt_q;
    sum1_d      = sum1_q;
    sum2_d      = sum2_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    busy_d      = busy_q;
    out1_d      = out1_q;
    out2_d      = out2_q;
    mean1_d     = mean1_q;
    mean2_d     = mean2_q;
    wr_en_s     = 1'b0;
    rd_en_s     = 1'b0;
    rd_addr_s   = '0;

    case (state_q)
      S_LOAD: begin
        if (in_xfer_s) begin
          wr_en_s = 1'b1;
          sum1_d  = sum1_q + SW'(IN_x1);
          sum2_d  = sum2_q + SW'(IN_x2);
          if (wcnt_q == LOG2N'(N - 1)) begin
            in_ready_d = 1'b0;
            wcnt_d     = '0;
            state_d    = S_MEAN;
          end else begin
            in_ready_d = 1'b1;
            wcnt_d     = wcnt_q + LOG2N'(1);
          end
        end else begin
          in_ready_d = 1'b1;
        end
      end

      S_MEAN: begin
        // Dropping the low LOG2N bits is an arithmetic shift: floor(sum/N)
        mean1_d   = sum1_q[SW-1:LOG2N];
        mean2_d   = sum2_q[SW-1:LOG2N];
        rd_en_s   = 1'b1;
        rd_addr_s = '0;
        rcnt_d    = '0;
        state_d   = S_OUT;
      end

      S_OUT: begin
        // rd*_q always holds the word after the one being presented
        if (!out_valid_q) begin
          out1_d      = diff1_s;
          out2_d      = diff2_s;
          out_valid_d = 1'b1;
          rd_en_s     = 1'b1;
          rd_addr_s   = rcnt_q + LOG2N'(1);
        end else if (OUT_ready) begin
          if (rcnt_q == LOG2N'(N - 1)) begin
            out_valid_d = 1'b0;
            busy_d      = 1'b0;
            state_d     = S_DONE;
          end else begin
            out1_d    = diff1_s;
            out2_d    = diff2_s;
            rcnt_d    = rcnt_q + LOG2N'(1);
            rd_en_s   = 1'b1;
            rd_addr_s = rcnt_q + LOG2N'(2);
          end
        end else begin
          out_valid_d = 1'b1;
        end
      end

      S_DONE: begin
        busy_d      = 1'b0;
        in_ready_d  = 1'b0;
        out_valid_d = 1'b0;
      end

      default: begin
        state_d = S_LOAD;
      end
    endcase
  end

  // Control and output registers, cleared asynchronously while GO is low
  always_ff @(posedge CLK or negedge GO) begin
    if (!GO) begin
      state_q     <= S_LOAD;
      wcnt_q      <= '0;
      rcnt_q      <= '0;
      sum1_q      <= '0;
      sum2_q      <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b1;
      out1_q      <= '0;
      out2_q      <= '0;
      mean1_q     <= '0;
      mean2_q     <= '0;
    end else begin
      state_q     <= state_d;
      wcnt_q      <= wcnt_d;
      rcnt_q      <= rcnt_d;
      sum1_q      <= sum1_d;
      sum2_q      <= sum2_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
      out1_q      <= out1_d;
      out2_q      <= out2_d;
      mean1_q     <= mean1_d;
      mean2_q     <= mean2_d;
    end
  end

  // Sample buffer write port; contents need no reset
  always_ff @(posedge CLK) begin
    if (wr_en_s) begin
      buf1[wcnt_q] <= IN_x1;
      buf2[wcnt_q] <= IN_x2;
    end
  end

  // Sample buffer registered read port
  always_ff @(posedge CLK) begin
    if (rd_en_s) begin
      rd1_q <= buf1[rd_addr_s];
      rd2_q <= buf2[rd_addr_s];
    end
  end

  assign IN_ready  = in_ready_q;
  assign OUT_valid = out_valid_q;
  assign OUT_x1    = out1_q;
  assign OUT_x2    = out2_q;
  assign MEAN_x1   = mean1_q;
  assign MEAN_x2   = mean2_q;
  assign CEN_busy  = busy_q;

endmodule

// File: tb/tb_centering_unit.sv
// Self-checking bench for centering_unit: randomized frames checked against a
// floor-mean reference model held in plain integer arrays.
module tb_centering_unit;

  localparam int N     = 128;
  localparam int LOG2N = 7;
  localparam int W     = 16;

  logic                CLK = 1'b0;
  logic                GO;
  logic                IN_valid;
  logic                IN_ready;
  logic signed [W-1:0] IN_x1, IN_x2;
  logic                OUT_valid;
  logic                OUT_ready;
  logic signed [W:0]   OUT_x1, OUT_x2;
  logic signed [W-1:0] MEAN_x1, MEAN_x2;
  logic                CEN_busy;

  centering_unit #(.N(N), .LOG2N(LOG2N), .W(W)) dut (
    .CLK(CLK), .GO(GO),
    .IN_valid(IN_valid), .IN_ready(IN_ready), .IN_x1(IN_x1), .IN_x2(IN_x2),
    .OUT_valid(OUT_valid), .OUT_ready(OUT_ready), .OUT_x1(OUT_x1), .OUT_x2(OUT_x2),
    .MEAN_x1(MEAN_x1), .MEAN_x2(MEAN_x2), .CEN_busy(CEN_busy)
  );

  always #5 CLK = ~CLK;

  int n_cmp = 0;
  int n_bad = 0;

  int                in1 [N];
  int                in2 [N];
  logic signed [W:0] cap1 [N];
  logic signed [W:0] cap2 [N];
  int   n_in, n_out, k_last_in, m_first_out, j_last_out, b_busy_fall;
  int   hold_err, in_rdy_late, busy_err;
  logic valid_at_fall;
  bit   timed_out;

  // Reference: floor of the arithmetic mean, computed with plain integer math
  function automatic int model_mean(input int ch);
    int s = 0;
    for (int i = 0; i < N; i++) s += (ch == 1) ? in1[i] : in2[i];
    if (s >= 0) return s / N;
    return -((-s + N - 1) / N);
  endfunction

  function automatic int rnd_sample();
    return int'($urandom_range(0, 65535)) - 32768;
  endfunction

  task automatic start_frame();
    @(negedge CLK); GO = 1'b0; IN_valid = 1'b0; OUT_ready = 1'b0;
    @(negedge CLK); GO = 1'b1;
  endtask

  // Drives one frame and records what came out; the tests judge the record
  task automatic drive_frame(input int gap_pct, input int ordy_pct, input int stall_at,
                             input int stall_len, input int abort_at);
    int cyc = 0;
    int stall_left = 0;
    bit prev_stall = 1'b0;
    bit stall_done = 1'b0;
    bit done = 1'b0;
    logic signed [W:0] prev1 = '0;
    logic signed [W:0] prev2 = '0;
    n_in = 0; n_out = 0; k_last_in = -1; m_first_out = -1; j_last_out = -1;
    b_busy_fall = -1; hold_err = 0; in_rdy_late = 0; busy_err = 0;
    valid_at_fall = 1'bx; timed_out = 1'b0;
    for (int i = 0; i < N; i++) begin cap1[i] = 'x; cap2[i] = 'x; end
    while (!done) begin
      @(negedge CLK);
      cyc++;
      if (prev_stall && (OUT_valid !== 1'b1 || OUT_x1 !== prev1 || OUT_x2 !== prev2)) hold_err++;
      if (n_in == N && IN_ready !== 1'b0) in_rdy_late++;
      if (OUT_valid === 1'b1 && m_first_out < 0) m_first_out = cyc;
      if (n_out == N && CEN_busy === 1'b0) begin
        b_busy_fall = cyc; valid_at_fall = OUT_valid;
        IN_valid = 1'b0; OUT_ready = 1'b0; done = 1'b1;
      end else if (abort_at >= 0 && n_out == abort_at && OUT_valid === 1'b1) begin
        GO = 1'b0; IN_valid = 1'b0; OUT_ready = 1'b0;
        #1;
        done = 1'b1;
      end else if (cyc > 4000) begin
        timed_out = 1'b1; IN_valid = 1'b0; OUT_ready = 1'b0; done = 1'b1;
      end else begin
        if (CEN_busy !== 1'b1) busy_err++;
        IN_valid = (n_in < N) && (int'($urandom_range(0, 99)) >= gap_pct);
        IN_x1 = (n_in < N) ? W'(in1[n_in]) : W'($urandom);
        IN_x2 = (n_in < N) ? W'(in2[n_in]) : W'($urandom);
        if (IN_valid && IN_ready === 1'b1) begin k_last_in = cyc; n_in++; end
        if (stall_at >= 0 && !stall_done && n_out == stall_at && OUT_valid === 1'b1) begin
          stall_left = stall_len; stall_done = 1'b1;
        end
        if (stall_left > 0) begin
          OUT_ready = 1'b0; stall_left--;
        end else begin
          OUT_ready = (int'($urandom_range(0, 99)) < ordy_pct);
        end
        prev_stall = (OUT_valid === 1'b1) && !OUT_ready;
        prev1 = OUT_x1; prev2 = OUT_x2;
        if (OUT_valid === 1'b1 && OUT_ready) begin
          cap1[n_out] = OUT_x1; cap2[n_out] = OUT_x2; n_out++; j_last_out = cyc;
        end
      end
    end
  endtask

  task automatic test_reset();
    GO = 1'b1; IN_valid = 1'b0; OUT_ready = 1'b0; IN_x1 = '0; IN_x2 = '0;
    #1 GO = 1'b0;
    #2;
    n_cmp++;
    if (IN_ready !== 1'b0 || OUT_valid !== 1'b0 || CEN_busy !== 1'b1) begin
      n_bad++;
      $display("FAIL reset_ctrl: got rdy=%b vld=%b busy=%b want 0 0 1", IN_ready, OUT_valid, CEN_busy);
    end
    n_cmp++;
    if (OUT_x1 !== '0 || OUT_x2 !== '0 || MEAN_x1 !== '0 || MEAN_x2 !== '0) begin
      n_bad++;
      $display("FAIL reset_data: got out=%0d/%0d mean=%0d/%0d want all 0", OUT_x1, OUT_x2, MEAN_x1, MEAN_x2);
    end
    @(negedge CLK);
    n_cmp++;
    if (IN_ready !== 1'b0) begin n_bad++; $display("FAIL reset_hold_rdy: got %b want 0", IN_ready); end
    GO = 1'b1;
    @(negedge CLK);
    n_cmp++;
    if (IN_ready !== 1'b1) begin n_bad++; $display("FAIL reset_rdy_rise: got %b want 1", IN_ready); end
  endtask

  task automatic test_constant();
    integer g1, g2;
    for (int i = 0; i < N; i++) begin in1[i] = 100; in2[i] = -7; end
    start_frame();
    drive_frame(0, 100, -1, 0, -1);
    n_cmp++;
    if (timed_out) begin n_bad++; $display("FAIL const_timeout: got n_out=%0d want %0d", n_out, N); end
    g1 = MEAN_x1; g2 = MEAN_x2;
    n_cmp++;
    if (g1 !== 100 || g2 !== -7) begin n_bad++; $display("FAIL const_mean: got %0d/%0d want 100/-7", g1, g2); end
    for (int i = 0; i < N; i++) begin
      g1 = cap1[i]; g2 = cap2[i];
      n_cmp++;
      if (g1 !== 0 || g2 !== 0) begin n_bad++; $display("FAIL const_sample[%0d]: got %0d/%0d want 0/0", i, g1, g2); end
    end
    n_cmp++;
    if (m_first_out - k_last_in !== 3) begin
      n_bad++; $display("FAIL const_latency: got %0d edges want 2", m_first_out - k_last_in - 1);
    end
    n_cmp++;
    if (j_last_out - m_first_out !== N - 1) begin
      n_bad++; $display("FAIL const_bubbles: got span %0d want %0d", j_last_out - m_first_out, N - 1);
    end
  endtask

  task automatic test_ramp();
    integer g1, g2;
    int m1, m2;
    for (int i = 0; i < N; i++) begin in1[i] = i; in2[i] = rnd_sample(); end
    m1 = model_mean(1); m2 = model_mean(2);
    start_frame();
    drive_frame(0, 100, -1, 0, -1);
    n_cmp++;
    if (timed_out) begin n_bad++; $display("FAIL ramp_timeout: got n_out=%0d want %0d", n_out, N); end
    g1 = MEAN_x1; g2 = MEAN_x2;
    n_cmp++;
    if (g1 !== 63 || g2 !== m2) begin n_bad++; $display("FAIL ramp_mean: got %0d/%0d want 63/%0d", g1, g2, m2); end
    for (int i = 0; i < N; i++) begin
      g1 = cap1[i]; g2 = cap2[i];
      n_cmp++;
      if (g1 !== in1[i] - m1 || g2 !== in2[i] - m2) begin
        n_bad++; $display("FAIL ramp_sample[%0d]: got %0d/%0d want %0d/%0d", i, g1, g2, in1[i] - m1, in2[i] - m2);
      end
    end
    n_cmp++;
    if (b_busy_fall !== j_last_out + 1 || valid_at_fall !== 1'b0 || busy_err !== 0) begin
      n_bad++;
      $display("FAIL ramp_busy: got fall=%0d vld=%b early=%0d want fall=%0d vld=0 early=0",
               b_busy_fall, valid_at_fall, busy_err, j_last_out + 1);
    end
  endtask

  task automatic test_extreme();
    integer g1, g2;
    for (int i = 0; i < N; i++) begin
      in1[i] = (i % 2 == 0) ? 32767 : -32768;
      in2[i] = (i % 2 == 0) ? -32768 : 32767;
    end
    start_frame();
    drive_frame(0, 100, -1, 0, -1);
    n_cmp++;
    if (timed_out) begin n_bad++; $display("FAIL extreme_timeout: got n_out=%0d want %0d", n_out, N); end
    g1 = MEAN_x1; g2 = MEAN_x2;
    n_cmp++;
    if (g1 !== -1 || g2 !== -1) begin n_bad++; $display("FAIL extreme_mean: got %0d/%0d want -1/-1", g1, g2); end
    for (int i = 0; i < N; i++) begin
      g1 = cap1[i]; g2 = cap2[i];
      n_cmp++;
      if (g1 !== in1[i] + 1 || g2 !== in2[i] + 1) begin
        n_bad++; $display("FAIL extreme_sample[%0d]: got %0d/%0d want %0d/%0d", i, g1, g2, in1[i] + 1, in2[i] + 1);
      end
    end
  endtask

  task automatic test_handshake(input int gap_pct, input int ordy_pct, input int stall_at);
    integer g1, g2;
    int m1, m2;
    for (int i = 0; i < N; i++) begin in1[i] = rnd_sample(); in2[i] = rnd_sample(); end
    m1 = model_mean(1); m2 = model_mean(2);
    start_frame();
    drive_frame(gap_pct, ordy_pct, stall_at, 5, -1);
    n_cmp++;
    if (timed_out || n_in !== N || n_out !== N) begin
      n_bad++; $display("FAIL hs_count: got in=%0d out=%0d want %0d/%0d", n_in, n_out, N, N);
    end
    n_cmp++;
    if (hold_err !== 0) begin n_bad++; $display("FAIL hs_hold: got %0d unstable stalls want 0", hold_err); end
    n_cmp++;
    if (in_rdy_late !== 0) begin n_bad++; $display("FAIL hs_in_ready: got %0d late cycles want 0", in_rdy_late); end
    g1 = MEAN_x1; g2 = MEAN_x2;
    n_cmp++;
    if (g1 !== m1 || g2 !== m2) begin n_bad++; $display("FAIL hs_mean: got %0d/%0d want %0d/%0d", g1, g2, m1, m2); end
    for (int i = 0; i < N; i++) begin
      g1 = cap1[i]; g2 = cap2[i];
      n_cmp++;
      if (g1 !== in1[i] - m1 || g2 !== in2[i] - m2) begin
        n_bad++; $display("FAIL hs_sample[%0d]: got %0d/%0d want %0d/%0d", i, g1, g2, in1[i] - m1, in2[i] - m2);
      end
    end
  endtask

  task automatic test_abort();
    integer g1, g2;
    for (int i = 0; i < N; i++) begin in1[i] = rnd_sample(); in2[i] = rnd_sample(); end
    start_frame();
    drive_frame(0, 100, -1, 0, 40);
    n_cmp++;
    if (n_out !== 40) begin n_bad++; $display("FAIL abort_point: got n_out=%0d want 40", n_out); end
    n_cmp++;
    if (IN_ready !== 1'b0 || OUT_valid !== 1'b0 || CEN_busy !== 1'b1 || OUT_x1 !== '0 || OUT_x2 !== '0
        || MEAN_x1 !== '0 || MEAN_x2 !== '0) begin
      n_bad++;
      $display("FAIL abort_reset: got rdy=%b vld=%b busy=%b out=%0d/%0d mean=%0d/%0d want 0 0 1 0/0 0/0",
               IN_ready, OUT_valid, CEN_busy, OUT_x1, OUT_x2, MEAN_x1, MEAN_x2);
    end
    @(negedge CLK); GO = 1'b1;
    for (int i = 0; i < N; i++) begin in1[i] = 5; in2[i] = 5; end
    drive_frame(0, 100, -1, 0, -1);
    n_cmp++;
    if (timed_out || n_out !== N) begin n_bad++; $display("FAIL abort_refill: got n_out=%0d want %0d", n_out, N); end
    g1 = MEAN_x1; g2 = MEAN_x2;
    n_cmp++;
    if (g1 !== 5 || g2 !== 5) begin n_bad++; $display("FAIL abort_mean: got %0d/%0d want 5/5", g1, g2); end
    for (int i = 0; i < N; i++) begin
      g1 = cap1[i]; g2 = cap2[i];
      n_cmp++;
      if (g1 !== 0 || g2 !== 0) begin n_bad++; $display("FAIL abort_sample[%0d]: got %0d/%0d want 0/0", i, g1, g2); end
    end
  endtask

  task automatic test_idle_after_done();
    logic signed [W-1:0] m1, m2;
    m1 = MEAN_x1; m2 = MEAN_x2;
    for (int c = 0; c < 20; c++) begin
      @(negedge CLK);
      IN_valid = 1'b1; IN_x1 = W'($urandom); IN_x2 = W'($urandom); OUT_ready = 1'($urandom);
      @(negedge CLK);
      n_cmp++;
      if (IN_ready !== 1'b0 || OUT_valid !== 1'b0 || CEN_busy !== 1'b0 || MEAN_x1 !== m1 || MEAN_x2 !== m2) begin
        n_bad++;
        $display("FAIL idle_cycle[%0d]: got rdy=%b vld=%b busy=%b mean=%0d/%0d want 0 0 0 %0d/%0d",
                 c, IN_ready, OUT_valid, CEN_busy, MEAN_x1, MEAN_x2, m1, m2);
      end
    end
    IN_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_constant();
    test_ramp();
    test_extreme();
    test_handshake(30, 100, 10);
    test_handshake(50, 60, -1);
    test_abort();
    test_idle_after_done();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
